// File: rtl/mod_bank_scheduler.sv
// Playback address sequencer for the double-banked modulation table; new configs swap in at wrap.
// Optional MOD_BANK_SCHED_LOOP_CNT_EN adds LOOP_CNT (wraps since last swap/START, saturating).
module mod_bank_scheduler #(
  parameter int IDX_W = 15,
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REF_CLK_TICK,
  input  logic             START,
  input  logic             STOP,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [15:0]      CFG_CYCLE,
  input  logic [DIV_W-1:0] CFG_DIV,
  input  logic             CFG_BANK,
  output logic [IDX_W:0]   MOD_ADDR,
  output logic [IDX_W-1:0] ACTIVE_CYCLE,
  output logic             RUNNING,
  output logic             WRAP,
`ifdef MOD_BANK_SCHED_LOOP_CNT_EN
  output logic [15:0]      LOOP_CNT,
`endif
  output logic             SWAP_DONE
);

  // state  | meaning
  // S_IDLE | idx/div held at 0; pending config applied on the next edge
  // S_RUN  | stepping on REF_CLK_TICK; pending config applied only at wrap
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [16:0] MAX_CYC = 17'((1 << IDX_W) - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [DIV_W-1:0] div_cnt;
  logic             active_bank;
  logic [IDX_W-1:0] active_cycle;
  logic [DIV_W-1:0] active_div;
  logic             pending_valid;
  logic             pending_bank;
  logic [IDX_W-1:0] pending_cycle;
  logic [DIV_W-1:0] pending_div;
  logic             wrap_q;
  logic             swap_q;
  logic [IDX_W-1:0] cfg_cycle_sat;
`ifdef MOD_BANK_SCHED_LOOP_CNT_EN
  logic [15:0]      loop_cnt;
`endif

  always_comb begin
    cfg_cycle_sat = CFG_CYCLE[IDX_W-1:0];
    if ({1'b0, CFG_CYCLE} > MAX_CYC) cfg_cycle_sat = '1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= S_IDLE;
      idx           <= '0;
      div_cnt       <= '0;
      active_bank   <= 1'b0;
      active_cycle  <= '0;
      active_div    <= '0;
      pending_valid <= 1'b0;
      pending_bank  <= 1'b0;
      pending_cycle <= '0;
      pending_div   <= '0;
      wrap_q        <= 1'b0;
      swap_q        <= 1'b0;
`ifdef MOD_BANK_SCHED_LOOP_CNT_EN
      loop_cnt      <= '0;
`endif
    end else begin
      wrap_q <= 1'b0;
      swap_q <= 1'b0;
      // Accept only into an empty slot; the slot is drained below only when full, so no overlap.
      if (CFG_VALID && !pending_valid) begin
        pending_valid <= 1'b1;
        pending_cycle <= cfg_cycle_sat;
        pending_div   <= CFG_DIV;
        pending_bank  <= CFG_BANK;
      end
      case (state)
        S_IDLE: begin
          idx     <= '0;
          div_cnt <= '0;
          if (pending_valid) begin
            active_cycle  <= pending_cycle;
            active_div    <= pending_div;
            active_bank   <= pending_bank;
            pending_valid <= 1'b0;
            swap_q        <= 1'b1;
`ifdef MOD_BANK_SCHED_LOOP_CNT_EN
            loop_cnt      <= '0;
`endif
          end
          if (START && !STOP) begin
            state <= S_RUN;
`ifdef MOD_BANK_SCHED_LOOP_CNT_EN
            loop_cnt <= '0;
`endif
          end
        end
        S_RUN: begin
          if (STOP) begin
            state   <= S_IDLE;
            idx     <= '0;
            div_cnt <= '0;
          end else if (REF_CLK_TICK) begin
            if (div_cnt == active_div) begin
              div_cnt <= '0;
              if (idx == active_cycle) begin
                idx    <= '0;
                wrap_q <= 1'b1;
                if (pending_valid) begin
                  active_cycle  <= pending_cycle;
                  active_div    <= pending_div;
                  active_bank   <= pending_bank;
                  pending_valid <= 1'b0;
                  swap_q        <= 1'b1;
`ifdef MOD_BANK_SCHED_LOOP_CNT_EN
                  loop_cnt      <= '0;
                end else if (loop_cnt != 16'hFFFF) begin
                  loop_cnt <= loop_cnt + 16'd1;
`endif
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign MOD_ADDR     = {active_bank, idx};
  assign ACTIVE_CYCLE = active_cycle;
  assign RUNNING      = (state == S_RUN);
  assign WRAP         = wrap_q;
  assign SWAP_DONE    = swap_q;
  assign CFG_READY    = ~pending_valid;
`ifdef MOD_BANK_SCHED_LOOP_CNT_EN
  assign LOOP_CNT     = loop_cnt;
`endif

endmodule

// File: tb/tb_mod_bank_scheduler.sv
// Directed bench for mod_bank_scheduler: tick-count reference model checked every cycle plus literal spot checks.
module tb_mod_bank_scheduler;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REF_CLK_TICK = 1'b0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        CFG_VALID = 1'b0;
  logic        CFG_READY;
  logic [15:0] CFG_CYCLE = '0;
  logic [15:0] CFG_DIV = '0;
  logic        CFG_BANK = 1'b0;
  logic [15:0] MOD_ADDR;
  logic [14:0] ACTIVE_CYCLE;
  logic        RUNNING;
  logic        WRAP;
  logic        SWAP_DONE;
`ifdef MOD_BANK_SCHED_LOOP_CNT_EN
  logic [15:0] LOOP_CNT;
`endif

  int errors = 0;
  int checks = 0;

  mod_bank_scheduler dut (
    .CLK(CLK), .RST_N(RST_N), .REF_CLK_TICK(REF_CLK_TICK), .START(START), .STOP(STOP),
    .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY), .CFG_CYCLE(CFG_CYCLE), .CFG_DIV(CFG_DIV),
    .CFG_BANK(CFG_BANK), .MOD_ADDR(MOD_ADDR), .ACTIVE_CYCLE(ACTIVE_CYCLE), .RUNNING(RUNNING),
    .WRAP(WRAP),
`ifdef MOD_BANK_SCHED_LOOP_CNT_EN
    .LOOP_CNT(LOOP_CNT),
`endif
    .SWAP_DONE(SWAP_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: playback position derived from ticks since START/swap.
  bit     m_run, m_wrap, m_swap, a_bank, p_v, p_bank;
  longint m_ticks;
  int     a_cyc, a_div, p_cyc, p_div, m_loop;

  task automatic model_reset();
    m_run = 0; m_wrap = 0; m_swap = 0; m_ticks = 0; m_loop = 0;
    a_cyc = 0; a_div = 0; a_bank = 0; p_v = 0; p_cyc = 0; p_div = 0; p_bank = 0;
  endtask

  task automatic model_swap();
    a_cyc = p_cyc; a_div = p_div; a_bank = p_bank; p_v = 0; m_swap = 1; m_loop = 0;
  endtask

  task automatic model_step();
    bit acc;
    longint period;
    acc = CFG_VALID && !p_v;
    m_wrap = 0; m_swap = 0;
    if (m_run) begin
      if (STOP) begin
        m_run = 0; m_ticks = 0;
      end else if (REF_CLK_TICK) begin
        period = longint'(a_div + 1) * longint'(a_cyc + 1);
        m_ticks++;
        if (m_ticks % period == 0) begin
          m_wrap = 1;
          if (p_v) begin model_swap(); m_ticks = 0; end
          else if (m_loop < 65535) m_loop++;
        end
      end
    end else begin
      if (p_v) model_swap();
      if (START && !STOP) begin m_run = 1; m_ticks = 0; m_loop = 0; end
    end
    if (acc) begin
      p_v = 1; p_cyc = (CFG_CYCLE > 16'h7FFF) ? 32'h7FFF : int'(CFG_CYCLE);
      p_div = int'(CFG_DIV); p_bank = CFG_BANK;
    end
  endtask

  always @(negedge CLK) begin
    int exp_idx;
    if (!RST_N) model_reset();
    exp_idx = m_run ? int'((m_ticks / (a_div + 1)) % (a_cyc + 1)) : 0;
    chk("model_addr", 32'(MOD_ADDR), 32'({a_bank, exp_idx[14:0]}));
    chk("model_running", 32'(RUNNING), 32'(m_run));
    chk("model_wrap", 32'(WRAP), 32'(m_wrap));
    chk("model_swap", 32'(SWAP_DONE), 32'(m_swap));
    chk("model_ready", 32'(CFG_READY), 32'(!p_v));
    chk("model_active_cycle", 32'(ACTIVE_CYCLE), 32'(a_cyc));
`ifdef MOD_BANK_SCHED_LOOP_CNT_EN
    chk("model_loop_cnt", 32'(LOOP_CNT), 32'(m_loop));
`endif
    if (RST_N) model_step();
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic load_idle(input logic [15:0] c, input logic [15:0] d, input logic b);
    CFG_VALID = 1; CFG_CYCLE = c; CFG_DIV = d; CFG_BANK = b;
    cyc();
    CFG_VALID = 0;
    cyc();
  endtask

  initial begin
    int seq[9];
    int ad[7], sw[7], wr[7], rd[7];
    cyc(3);
    chk("reset_addr", 32'(MOD_ADDR), 32'h0);
    chk("reset_ready", 32'(CFG_READY), 32'h1);
    chk("reset_running", 32'(RUNNING), 32'h0);
    RST_N = 1;
    cyc();

    // Config in IDLE: swap two edges after accept
    CFG_VALID = 1; CFG_CYCLE = 3; CFG_DIV = 0; CFG_BANK = 1;
    cyc();
    chk("idle_accept_ready", 32'(CFG_READY), 32'h0);
    chk("idle_accept_swap", 32'(SWAP_DONE), 32'h0);
    CFG_VALID = 0;
    cyc();
    chk("idle_swap_done", 32'(SWAP_DONE), 32'h1);
    chk("idle_swap_addr", 32'(MOD_ADDR), 32'h8000);
    chk("idle_swap_ready", 32'(CFG_READY), 32'h1);

    // Stepping with div=1
    load_idle(16'd3, 16'd1, 1'b0);
    START = 1; cyc(); START = 0;
    chk("step_running", 32'(RUNNING), 32'h1);
    seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    chk("step_idx0", 32'(MOD_ADDR), 32'(seq[0]));
    REF_CLK_TICK = 1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("step_idx", 32'(MOD_ADDR), 32'(seq[i+1]));
      chk("step_wrap", 32'(WRAP), 32'(i == 7));
    end
    REF_CLK_TICK = 0;

    // Boundary swap: cycle=4 bank0, new {2, bank1} accepted at idx=1
    STOP = 1; cyc(); STOP = 0;
    chk("stop_running", 32'(RUNNING), 32'h0);
    load_idle(16'd4, 16'd0, 1'b0);
    START = 1; cyc(); START = 0;
    REF_CLK_TICK = 1;
    cyc();
    chk("bswap_idx1", 32'(MOD_ADDR), 32'h1);
    CFG_VALID = 1; CFG_CYCLE = 2; CFG_DIV = 0; CFG_BANK = 1;
    ad = '{2, 3, 4, 'h8000, 'h8001, 'h8002, 'h8000};
    sw = '{0, 0, 0, 1, 0, 0, 0};
    wr = '{0, 0, 0, 1, 0, 0, 1};
    rd = '{0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      cyc();
      CFG_VALID = 0;
      chk("bswap_addr", 32'(MOD_ADDR), 32'(ad[i]));
      chk("bswap_swap", 32'(SWAP_DONE), 32'(sw[i]));
      chk("bswap_wrap", 32'(WRAP), 32'(wr[i]));
      chk("bswap_ready", 32'(CFG_READY), 32'(rd[i]));
    end

    // Accept on the wrap edge waits for the next wrap; second offer while pending ignored
    cyc(2);
    chk("simul_idx2", 32'(MOD_ADDR), 32'h8002);
    CFG_VALID = 1; CFG_CYCLE = 1; CFG_DIV = 0; CFG_BANK = 0;
    cyc();
    chk("simul_wrap", 32'(WRAP), 32'h1);
    chk("simul_noswap", 32'(SWAP_DONE), 32'h0);
    chk("simul_ready", 32'(CFG_READY), 32'h0);
    chk("simul_active", 32'(ACTIVE_CYCLE), 32'h2);
    CFG_CYCLE = 3;
    cyc(2);
    CFG_VALID = 0;
    chk("simul_busy_ready", 32'(CFG_READY), 32'h0);
    cyc();
    chk("simul_swap", 32'(SWAP_DONE), 32'h1);
    chk("simul_active2", 32'(ACTIVE_CYCLE), 32'h1);
    chk("simul_addr", 32'(MOD_ADDR), 32'h0);

    // Control
    REF_CLK_TICK = 0; STOP = 1; cyc(); STOP = 0;
    load_idle(16'd5, 16'd0, 1'b0);
    START = 1; cyc(); START = 0;
    REF_CLK_TICK = 1; cyc(3);
    chk("ctl_idx3", 32'(MOD_ADDR), 32'h3);
    STOP = 1; cyc(); STOP = 0; REF_CLK_TICK = 0;
    chk("ctl_stop_running", 32'(RUNNING), 32'h0);
    chk("ctl_stop_addr", 32'(MOD_ADDR), 32'h0);
    START = 1; STOP = 1; cyc(); START = 0; STOP = 0;
    chk("ctl_startstop", 32'(RUNNING), 32'h0);
    load_idle(16'hFFFF, 16'd0, 1'b0);
    chk("ctl_saturate", 32'(ACTIVE_CYCLE), 32'h7FFF);

    // cycle=0, div=0: wrap on every tick
    load_idle(16'd0, 16'd0, 1'b0);
    START = 1; cyc(); START = 0;
    REF_CLK_TICK = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("zero_wrap", 32'(WRAP), 32'h1);
      chk("zero_addr", 32'(MOD_ADDR), 32'h0);
    end
    REF_CLK_TICK = 0;

    // Async reset mid-run drops the pending config
    STOP = 1; cyc(); STOP = 0;
    load_idle(16'd7, 16'd0, 1'b1);
    START = 1; cyc(); START = 0;
    REF_CLK_TICK = 1; cyc(3); REF_CLK_TICK = 0;
    chk("rst_pre_addr", 32'(MOD_ADDR), 32'h8003);
    CFG_VALID = 1; CFG_CYCLE = 2; CFG_DIV = 0; CFG_BANK = 0;
    cyc(); CFG_VALID = 0;
    chk("rst_pre_ready", 32'(CFG_READY), 32'h0);
    RST_N = 0; #1;
    chk("rst_async_addr", 32'(MOD_ADDR), 32'h0);
    chk("rst_async_running", 32'(RUNNING), 32'h0);
    chk("rst_async_ready", 32'(CFG_READY), 32'h1);
    cyc(); RST_N = 1; cyc(3);
    chk("rst_no_swap", 32'(SWAP_DONE), 32'h0);
    chk("rst_active", 32'(ACTIVE_CYCLE), 32'h0);

`ifdef MOD_BANK_SCHED_LOOP_CNT_EN
    START = 1; cyc(); START = 0;
    REF_CLK_TICK = 1; cyc(70000);
    chk("loop_saturate", 32'(LOOP_CNT), 32'hFFFF);
    CFG_VALID = 1; CFG_CYCLE = 0; CFG_DIV = 0; CFG_BANK = 1;
    cyc(); CFG_VALID = 0;
    cyc();
    chk("loop_swap_done", 32'(SWAP_DONE), 32'h1);
    chk("loop_cleared", 32'(LOOP_CNT), 32'h0);
    REF_CLK_TICK = 0;
`endif

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
